proc_run_ctrl: RTL and testbench

Parametrised reset-sequencer and run/step controller for the processor core. It takes the single board reset and releases per-unit resets in a fixed order: PC/fetch first, then register file, then data memory, with programmable spacing between them. After release it gates the core through a clock-enable in run, single-step or halt mode, and counts enabled cycles. It sits between the top-level clk/rst and the processor (and its bench), replacing the bare one-shot reset pulse.

---
 rtl/proc_ctrl_pkg.sv | 21 ++
 rtl/rise_detect.sv | 20 ++
 rtl/proc_run_ctrl.sv | 108 ++++++++++
 tb/tb_proc_run_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared encodings for the processor run/reset controller.
// Mode and FSM state enums plus a small compile-time helper.
package proc_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_STEP = 2'b01,
    MODE_HALT = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'b00,
    ST_RELEASE = 2'b01,
    ST_RUN     = 2'b10
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered 0->1 edge detector: one history flop, pulse while the input
// is high and the previous sample was low.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/proc_run_ctrl.sv
// Reset sequencer and run/step/halt clock-enable controller for the core.
// Releases stage resets in ascending order, then gates the core via clk_en.
module proc_run_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_GAP   = 2,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  input  logic [1:0]            mode,
  input  logic                  step,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  clk_en,
  output logic                  ready,
  output logic [CNT_W-1:0]      cycle_count
);

  localparam int CW = $clog2(max_int(HOLD_CYCLES, STAGE_GAP) + 1);
  localparam int SW = $clog2(NUM_STAGES) + 1;

  state_e        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] idx;
  logic          step_rise;
  logic          en_next;

  rise_detect u_step_rise (
    .clk  (clk),
    .rst_n(rst),
    .d    (step),
    .rise (step_rise)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    en_next = 1'b0;
    if (state == ST_RUN) begin
      case (mode)
        MODE_RUN:  en_next = 1'b1;
        MODE_STEP: en_next = step_rise;
        default:   en_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_ASSERT;
      cnt         <= '0;
      idx         <= '0;
      stage_rst   <= '1;
      clk_en      <= 1'b0;
      ready       <= 1'b0;
      cycle_count <= '0;
    end else if (sw_rst_req) begin
      state       <= ST_ASSERT;
      cnt         <= '0;
      idx         <= '0;
      stage_rst   <= '1;
      clk_en      <= 1'b0;
      ready       <= 1'b0;
      cycle_count <= '0;
    end else begin
      clk_en <= en_next;
      // Counts alongside the registered enable and saturates at all-ones.
      if (en_next && (cycle_count != '1)) cycle_count <= cycle_count + 1'b1;

      case (state)
        ST_ASSERT: begin
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            stage_rst[0] <= 1'b0;
            cnt          <= '0;
            if (NUM_STAGES == 1) begin
              ready <= 1'b1;
              state <= ST_RUN;
            end else begin
              idx   <= SW'(1);
              state <= ST_RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt == CW'(STAGE_GAP - 1)) begin
            cnt <= '0;
            for (int k = 0; k < NUM_STAGES; k++)
              if (SW'(k) == idx) stage_rst[k] <= 1'b0;
            idx <= idx + 1'b1;
            if (idx == SW'(NUM_STAGES - 1)) begin
              ready <= 1'b1;
              state <= ST_RUN;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN:  ;
        default: state <= ST_ASSERT;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Scoreboard bench for proc_run_ctrl: stimulus queues expected snapshots
// tagged with a cycle number, a negedge monitor pops and compares them.
module tb_proc_run_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_rst_req;
  logic [1:0] mode;
  logic       step;
  logic [2:0] stage_rst, stage_rst_b;
  logic       clk_en, clk_en_b, ready, ready_b;
  logic [31:0] cycle_count;
  logic [3:0]  cycle_count_b;

  proc_run_ctrl #(.HOLD_CYCLES(4), .NUM_STAGES(3), .STAGE_GAP(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .mode(mode), .step(step),
    .stage_rst(stage_rst), .clk_en(clk_en), .ready(ready), .cycle_count(cycle_count)
  );

  proc_run_ctrl #(.HOLD_CYCLES(4), .NUM_STAGES(3), .STAGE_GAP(2), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .mode(mode), .step(step),
    .stage_rst(stage_rst_b), .clk_en(clk_en_b), .ready(ready_b), .cycle_count(cycle_count_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at;
    bit          sat;
    logic [2:0]  srst;
    logic        en;
    logic        rdy;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc++;

  task automatic push(input int at, input string name, input logic [2:0] s,
                      input logic e, input logic r, input logic [31:0] c);
    exp_t x;
    x.at = at; x.sat = 1'b0; x.srst = s; x.en = e; x.rdy = r; x.cnt = c; x.name = name;
    q.push_back(x);
  endtask

  task automatic push_sat(input int at, input string name, input logic [31:0] c);
    exp_t x;
    x.at = at; x.sat = 1'b1; x.srst = '0; x.en = 1'b0; x.rdy = 1'b0; x.cnt = c; x.name = name;
    q.push_back(x);
  endtask

  task automatic check(input string name, input bit ok, input string detail);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: %s", name, cyc, detail);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      if (e.at < cyc)
        check(e.name, 1'b0, $sformatf("expectation for cycle %0d never sampled", e.at));
      else if (e.sat)
        check(e.name, cycle_count_b === e.cnt[3:0],
              $sformatf("got cnt=%0d want cnt=%0d", cycle_count_b, e.cnt[3:0]));
      else
        check(e.name, {stage_rst, clk_en, ready, cycle_count} === {e.srst, e.en, e.rdy, e.cnt},
              $sformatf("got srst=%b en=%b rdy=%b cnt=%0d want srst=%b en=%b rdy=%b cnt=%0d",
                        stage_rst, clk_en, ready, cycle_count, e.srst, e.en, e.rdy, e.cnt));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic till(input int t);
    while (cyc < t) tick(1);
  endtask

  int b, c, s;

  initial begin
    rst = 1'b0; sw_rst_req = 1'b0; mode = 2'b00; step = 1'b0;
    push(1, "reset_state", 3'b111, 0, 0, 0);
    tick(3);
    rst = 1'b1;
    b = cyc;

    // Release order, run counting and saturation of the narrow counter.
    push(b + 3,  "hold_not_done", 3'b111, 0, 0, 0);
    push(b + 4,  "stage0_drop",   3'b110, 0, 0, 0);
    push(b + 5,  "gap_wait",      3'b110, 0, 0, 0);
    push(b + 6,  "stage1_drop",   3'b100, 0, 0, 0);
    push(b + 8,  "stage2_ready",  3'b000, 0, 1, 0);
    push(b + 9,  "run_first_en",  3'b000, 1, 1, 1);
    push(b + 13, "run_count5",    3'b000, 1, 1, 5);
    push_sat(b + 23, "sat_reach15", 15);
    push_sat(b + 28, "sat_hold15",  15);
    till(b + 28);

    // Halt holds the count; returning to run resumes on the next edge.
    mode = 2'b10;
    push(b + 29, "halt_first",  3'b000, 0, 1, 20);
    push(b + 34, "halt_last",   3'b000, 0, 1, 20);
    till(b + 34);
    mode = 2'b00;
    push(b + 35, "resume_run",  3'b000, 1, 1, 21);
    till(b + 35);
    c = cyc;

    // Step mode: one pulse per rising step edge, held step gives one pulse.
    mode = 2'b01;
    push(c + 1, "step_idle",     3'b000, 0, 1, 21);
    till(c + 1);
    step = 1'b1;
    push(c + 2, "step1_pulse",   3'b000, 1, 1, 22);
    push(c + 3, "step1_end",     3'b000, 0, 1, 22);
    push(c + 6, "step_held",     3'b000, 0, 1, 22);
    till(c + 6);
    step = 1'b0;
    till(c + 7);
    step = 1'b1;
    push(c + 8, "step2_pulse",   3'b000, 1, 1, 23);
    push(c + 9, "step2_end",     3'b000, 0, 1, 23);
    till(c + 9);

    // Step edge in halt is discarded, and does not fire after switching back.
    mode = 2'b10; step = 1'b0;
    till(c + 10);
    step = 1'b1;
    push(c + 11, "step_in_halt", 3'b000, 0, 1, 23);
    till(c + 11);
    mode = 2'b01;
    push(c + 12, "no_late_step", 3'b000, 0, 1, 23);
    till(c + 12);

    // Soft reset from RUN, then again mid-release.
    sw_rst_req = 1'b1;
    s = c + 13;
    push(s, "swrst_from_run", 3'b111, 0, 0, 0);
    till(s);
    sw_rst_req = 1'b0;
    push(s + 4, "sw_stage0",      3'b110, 0, 0, 0);
    push(s + 6, "sw_stage1",      3'b100, 0, 0, 0);
    till(s + 6);
    sw_rst_req = 1'b1;
    push(s + 7, "swrst_mid_rel",  3'b111, 0, 0, 0);
    till(s + 7);
    sw_rst_req = 1'b0;
    push(s + 10, "sw2_hold",      3'b111, 0, 0, 0);
    push(s + 11, "sw2_stage0",    3'b110, 0, 0, 0);
    push(s + 13, "sw2_stage1",    3'b100, 0, 0, 0);
    push(s + 15, "sw2_ready",     3'b000, 0, 1, 0);
    till(s + 15);
    mode = 2'b00;
    push(s + 16, "sw2_run",       3'b000, 1, 1, 1);

    // Async reset between edges: monitor samples before the next clock edge.
    push(s + 17, "async_rst",     3'b111, 0, 0, 0);
    push_sat(s + 17, "async_rst_sat", 0);
    till(s + 17);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;

    for (int i = 0; i < 20 && q.size() > 0; i++) tick(1);
    if (q.size() > 0) check("drain", 1'b0, $sformatf("%0d expectations left unchecked", q.size()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
